eic_prio_arbiter: RTL and testbench
===================================

// Module: eic_prio_arbiter
// PURPOSE
//  Priority scheduler for external interrupts between the IP interrupt lines and the core's ext-int handshake.
//  Latches rising edges into per-source pending bits and selects the highest-priority enabled source above threshold.
//  Drives a single trigger to the core and offers a bus-mapped claim/complete register pair.
//  Services one source at a time (no nesting); sits on the peripheral bus next to the other memory-mapped IPs.
// PARAMETERS
//  SRC_NUM  8  number of interrupt sources, 1..8; source IDs 0..SRC_NUM-1
//  PRIO_W   3  priority field width, 1..4; 0 = never signalled, larger value = more urgent
// PORTS
//  clk              in   1            clock; single clock domain
//  rstn             in   1            reset, synchronous, active-low
//  ext_int_trigger  out  1            interrupt request to core, registered
//  ext_int_handled  in   1            1-cycle pulse from core: current interrupt handled
//  ext_int_src_vect in   SRC_NUM      interrupt lines from IPs, posedge active
//  addr             in   5            byte address within block
//  w_rb             in   1            1 = write, 0 = read
//  acc              in   `BUS_ACC_WIDTH access size; only `BUS_ACC_4B legal
//  rdata            out  `BUS_WIDTH   read data, registered
//  wdata            in   `BUS_WIDTH   write data
//  req              in   1            access request, 1 cycle
//  resp             out  1            access done, 1 cycle after legal req
//  fault            out  1            combinational: req & illegal access
// BEHAVIOUR
//  Registers (unlisted bits read 0, writes ignored):
//   0x00 PEND  [SRC_NUM-1:0] RO pending; write-1-to-clear
//   0x04 EN    [SRC_NUM-1:0] RW enable mask
//   0x08 PRIO  nibble i = prio of src i, bits [4i+PRIO_W-1:4i] RW
//   0x0C THR   [PRIO_W-1:0] RW threshold; eligible iff pend&en&prio>THR
//   0x10 CLAIM read = claim; write = complete with ID in wdata[2:0]
//  Fault: acc!=`BUS_ACC_4B, addr[1:0]!=0 or addr>0x10. Faulting req: no resp, no side effect, rdata unchanged.
//  resp = registered (req & ~fault). rdata updated only on legal read, else holds.
//  Edge detect: prev <= src each cycle. Pending set when src high and prev low.
//  Set and clear (W1C/claim) of the same bit in one cycle: set wins. Edge on an already-pending bit is lost.
//  Arbitration: combinational over eligible sources; highest prio wins; tie -> lowest ID.
//   Result registered into win_id/win_vld.
//  FSM:
//   IDLE:   win_vld -> SIGNAL (trigger=1 from next cycle)
//   SIGNAL: win_id frozen; higher-prio arrivals wait.
//     CLAIM read -> rdata=win_id+1, clear pend[win_id], -> SERVICE.
//     handled pulse -> clear pend[win_id], -> IDLE.
//     win_id no longer eligible (W1C, EN or PRIO/THR change) -> IDLE.
//   SERVICE: trigger=0. Complete write with wdata[2:0]==win_id or handled pulse -> IDLE.
//     Mismatched complete ignored.
//  CLAIM read outside SIGNAL returns 0, no state change.
//  Latency: src rises before edge k -> pend bit 1 after k -> trigger 1 after edge k+2 (IDLE, eligible).
//  After complete, next eligible source triggers 2 cycles after IDLE re-entry.
//  Reset values: trigger, resp, rdata = 0; PEND, EN, PRIO, THR, prev, win = 0; FSM IDLE.
//   prev=0 means a source held high across reset yields one edge after reset.
//   Reset mid-service drops all state; no trigger until re-enabled.
// TESTING
//  Sources 2,5 enabled, prio 1 and 3, THR 0, both rise same cycle -> trigger after 2 cycles; CLAIM reads 6; after complete, CLAIM reads 3.
//  Src 3 prio 2 = THR 2 -> never triggers; write THR=1 -> trigger within 2 cycles.
//  Src 0 and 4 equal prio 5 -> CLAIM reads 1 first (lowest ID).
//  In SIGNAL, W1C PEND of winner -> trigger 0 next cycle, FSM IDLE; CLAIM reads 0.
//  acc=1B read of 0x04, and read of 0x14 -> fault=1 same cycle, resp stays 0, no state change.
//  In SERVICE, complete with wrong ID -> stays SERVICE; handled pulse -> IDLE; rstn low 1 cycle mid-SIGNAL -> all regs 0.

Source files
------------

// File: rtl/eic_prio_arbiter.sv
// eic_prio_arbiter
//   This block schedules external interrupts for the core. It latches rising
//   edges of the IP interrupt lines into pending bits, picks the most urgent
//   eligible source, and raises a single trigger to the core. Only one source
//   is serviced at a time. Software reaches it through a small bus register
//   file that includes a claim/complete register.
//
//   Ports
//     clk, rstn          clock; synchronous active-low reset
//     ext_int_trigger    registered interrupt request to the core
//     ext_int_handled    1-cycle pulse from the core: current interrupt handled
//     ext_int_src_vect   IP interrupt lines (rising edge active)
//     addr/w_rb/acc/req  bus access: byte address, write flag, size, request
//     wdata/rdata        bus write data / registered read data
//     resp               pulses one cycle after a legal request
//     fault              combinational flag for an illegal request
//
//   Register map
//     0x00 PEND   pending bits (read-only; writing 1 clears a bit)
//     0x04 EN     enable mask
//     0x08 PRIO   priority of source i in nibble i
//     0x0C THR    threshold; a source must have prio > THR to be signalled
//     0x10 CLAIM  read: claim (ID+1, or 0); write: complete with ID in [2:0]
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no interrupt in flight; arbitration result sampled each cycle
//   SIGNAL  | trigger high; winner frozen until claim, handled or loss
//   SERVICE | claimed by software; waits for matching complete or handled

`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module eic_prio_arbiter #(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  output logic                      ext_int_trigger,
  input  logic                      ext_int_handled,
  input  logic [SRC_NUM-1:0]        ext_int_src_vect,
  input  logic [4:0]                addr,
  input  logic                      w_rb,
  input  logic [`BUS_ACC_WIDTH-1:0] acc,
  output logic [`BUS_WIDTH-1:0]     rdata,
  input  logic [`BUS_WIDTH-1:0]     wdata,
  input  logic                      req,
  output logic                      resp,
  output logic                      fault
);

  localparam logic [4:0] A_PEND  = 5'h00;
  localparam logic [4:0] A_EN    = 5'h04;
  localparam logic [4:0] A_PRIO  = 5'h08;
  localparam logic [4:0] A_THR   = 5'h0C;
  localparam logic [4:0] A_CLAIM = 5'h10;

  typedef enum logic [1:0] {S_IDLE, S_SIGNAL, S_SERVICE} state_t;

  state_t                        state_q, state_d;
  logic [SRC_NUM-1:0]            pend_q, pend_d;
  logic [SRC_NUM-1:0]            en_q, en_d;
  logic [SRC_NUM-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [PRIO_W-1:0]             thr_q, thr_d;
  logic [SRC_NUM-1:0]            prev_q, prev_d;
  logic [2:0]                    win_id_q, win_id_d;
  logic                          win_vld_q, win_vld_d;
  logic                          trigger_q, trigger_d;
  logic                          resp_q, resp_d;
  logic [`BUS_WIDTH-1:0]         rdata_q, rdata_d;

  logic                          legal, wr_en, rd_en, claim_rd, complete_wr;
  logic [SRC_NUM-1:0]            elig_q, elig_d, pend_clr;
  logic [2:0]                    best_id;
  logic                          best_vld;
  logic [PRIO_W-1:0]             best_prio;
  logic [`BUS_WIDTH-1:0]         rd_val;
  logic                          unused_wdata;

  assign unused_wdata = ^wdata;

  always_comb begin
    fault       = req & ((acc != `BUS_ACC_4B) | (addr[1:0] != 2'b00) | (addr > A_CLAIM));
    legal       = req & ~fault;
    wr_en       = legal & w_rb;
    rd_en       = legal & ~w_rb;
    claim_rd    = rd_en & (addr == A_CLAIM);
    complete_wr = wr_en & (addr == A_CLAIM);
  end

  // Arbitration over current register state: strict '>' keeps the lowest ID on ties.
  always_comb begin
    best_id   = 3'd0;
    best_vld  = 1'b0;
    best_prio = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      elig_q[i] = pend_q[i] & en_q[i] & (prio_q[i] > thr_q);
      if (elig_q[i] && (!best_vld || prio_q[i] > best_prio)) begin
        best_id   = 3'(i);
        best_vld  = 1'b1;
        best_prio = prio_q[i];
      end
    end
  end

  always_comb begin
    en_d   = en_q;
    prio_d = prio_q;
    thr_d  = thr_q;
    if (wr_en && addr == A_EN)
      en_d = wdata[SRC_NUM-1:0];
    if (wr_en && addr == A_PRIO)
      for (int i = 0; i < SRC_NUM; i++)
        prio_d[i] = wdata[4*i +: PRIO_W];
    if (wr_en && addr == A_THR)
      thr_d = wdata[PRIO_W-1:0];

    pend_clr = '0;
    if (wr_en && addr == A_PEND)
      pend_clr = wdata[SRC_NUM-1:0];
    if (state_q == S_SIGNAL && (claim_rd || ext_int_handled))
      pend_clr[win_id_q] = 1'b1;
    prev_d = ext_int_src_vect;
    // A new edge beats a clear in the same cycle.
    pend_d = (ext_int_src_vect & ~prev_q) | (pend_q & ~pend_clr);

    // Winner eligibility is judged on next-cycle register values so a
    // W1C/EN/PRIO/THR change drops the trigger right after the write.
    for (int i = 0; i < SRC_NUM; i++)
      elig_d[i] = pend_d[i] & en_d[i] & (prio_d[i] > thr_d);
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      A_PEND:  rd_val[SRC_NUM-1:0] = pend_q;
      A_EN:    rd_val[SRC_NUM-1:0] = en_q;
      A_PRIO:  for (int i = 0; i < SRC_NUM; i++) rd_val[4*i +: PRIO_W] = prio_q[i];
      A_THR:   rd_val[PRIO_W-1:0] = thr_q;
      A_CLAIM: if (state_q == S_SIGNAL) rd_val[3:0] = {1'b0, win_id_q} + 4'd1;
      default: rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
    resp_d  = legal;
  end

  always_comb begin
    state_d   = state_q;
    win_id_d  = win_id_q;
    win_vld_d = win_vld_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld_q) begin
          state_d = S_SIGNAL;
        end else begin
          win_id_d  = best_id;
          win_vld_d = best_vld;
        end
      end
      S_SIGNAL: begin
        if (claim_rd) begin
          state_d = S_SERVICE;
        end else if (ext_int_handled || !elig_d[win_id_q]) begin
          state_d   = S_IDLE;
          win_vld_d = 1'b0;
        end
      end
      S_SERVICE: begin
        if ((complete_wr && wdata[2:0] == win_id_q) || ext_int_handled) begin
          state_d   = S_IDLE;
          win_vld_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        win_vld_d = 1'b0;
      end
    endcase
    trigger_d = (state_d == S_SIGNAL);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      en_q      <= '0;
      prio_q    <= '0;
      thr_q     <= '0;
      prev_q    <= '0;
      win_id_q  <= '0;
      win_vld_q <= 1'b0;
      trigger_q <= 1'b0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      prio_q    <= prio_d;
      thr_q     <= thr_d;
      prev_q    <= prev_d;
      win_id_q  <= win_id_d;
      win_vld_q <= win_vld_d;
      trigger_q <= trigger_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ext_int_trigger = trigger_q;
  assign resp            = resp_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_eic_prio_arbiter.sv
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_WIDTH
`define BUS_ACC_WIDTH 2
`endif
`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module tb_eic_prio_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trig;
  logic        handled = 1'b0;
  logic [7:0]  src = '0;
  logic [4:0]  addr = '0;
  logic        w_rb = 1'b0;
  logic [1:0]  acc = 2'd2;
  logic [31:0] rdata;
  logic [31:0] wdata = '0;
  logic        req = 1'b0;
  logic        resp;
  logic        fault;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  eic_prio_arbiter #(.SRC_NUM(8), .PRIO_W(3)) dut (
    .clk(clk), .rstn(rstn), .ext_int_trigger(trig), .ext_int_handled(handled),
    .ext_int_src_vect(src), .addr(addr), .w_rb(w_rb), .acc(acc), .rdata(rdata),
    .wdata(wdata), .req(req), .resp(resp), .fault(fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: interrupt controller described by its rules.
  int          m_st;      // 0 idle, 1 signalling, 2 in service
  bit [7:0]    m_pend, m_en, m_prev;
  int          m_prio[8];
  int          m_thr, m_win;
  bit          m_winv, m_trig, m_resp;
  logic [31:0] m_rdata;

  always @(posedge clk) begin : model
    int          arb;
    bit          legal, wr, rd, claim_rd, cmpl_wr, set, clr, w_ok;
    bit [7:0]    np, ne;
    int          npr[8];
    int          nthr;
    logic [31:0] pr;
    if (!rstn) begin
      m_st = 0; m_pend = 0; m_en = 0; m_prev = 0; m_thr = 0; m_win = 0;
      m_winv = 0; m_trig = 0; m_resp = 0; m_rdata = 0;
      for (int i = 0; i < 8; i++) m_prio[i] = 0;
    end else begin
      // most urgent level first, lowest ID within a level
      arb = -1;
      for (int p = 7; p > m_thr; p--)
        for (int i = 0; i < 8; i++)
          if (arb < 0 && m_pend[i] && m_en[i] && m_prio[i] == p) arb = i;

      legal    = req && acc == 2'd2 && addr[1:0] == 2'b00 && addr <= 5'h10;
      wr       = legal && w_rb;
      rd       = legal && !w_rb;
      claim_rd = rd && addr == 5'h10;
      cmpl_wr  = wr && addr == 5'h10;

      ne = (wr && addr == 5'h04) ? wdata[7:0] : m_en;
      nthr = (wr && addr == 5'h0C) ? int'(wdata[2:0]) : m_thr;
      for (int i = 0; i < 8; i++)
        npr[i] = (wr && addr == 5'h08) ? int'((wdata >> (4*i)) & 32'h7) : m_prio[i];
      for (int i = 0; i < 8; i++) begin
        set = src[i] && !m_prev[i];
        clr = (wr && addr == 5'h00 && wdata[i]) ||
              (m_st == 1 && (claim_rd || handled) && i == m_win);
        np[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
      end

      if (rd) begin
        pr = 0;
        for (int i = 0; i < 8; i++) pr = pr | (32'(m_prio[i]) << (4*i));
        case (addr)
          5'h00: m_rdata = {24'h0, m_pend};
          5'h04: m_rdata = {24'h0, m_en};
          5'h08: m_rdata = pr;
          5'h0C: m_rdata = 32'(m_thr);
          default: m_rdata = (m_st == 1) ? 32'(m_win + 1) : 32'h0;
        endcase
      end

      w_ok = np[m_win] && ne[m_win] && npr[m_win] > nthr;
      case (m_st)
        0: if (m_winv) m_st = 1;
           else begin m_winv = (arb >= 0); m_win = (arb >= 0) ? arb : 0; end
        1: if (claim_rd) m_st = 2;
           else if (handled || !w_ok) begin m_st = 0; m_winv = 0; end
        default: if ((cmpl_wr && int'(wdata[2:0]) == m_win) || handled) begin
                   m_st = 0; m_winv = 0;
                 end
      endcase

      m_pend = np; m_en = ne; m_thr = nthr;
      for (int i = 0; i < 8; i++) m_prio[i] = npr[i];
      m_prev = src;
      m_trig = (m_st == 1);
      m_resp = legal;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("trigger", {31'h0, trig}, {31'h0, m_trig});
      check("resp", {31'h0, resp}, {31'h0, m_resp});
      check("rdata", rdata, m_rdata);
      check("fault", {31'h0, fault},
            {31'h0, req && (acc != 2'd2 || addr[1:0] != 2'b00 || addr > 5'h10)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    addr = a; wdata = d; w_rb = 1'b1; acc = 2'd2; req = 1'b1;
    tick();
    req = 1'b0; w_rb = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    addr = a; w_rb = 1'b0; acc = 2'd2; req = 1'b1;
    tick();
    req = 1'b0;
    d = rdata;
  endtask

  task automatic wait_trig(input string name);
    int n = 0;
    while (!trig && n < 20) begin
      tick();
      n++;
    end
    check(name, {31'h0, trig}, 32'h1);
  endtask

  task automatic pulse_handled();
    handled = 1'b1;
    tick();
    handled = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    rstn = 1'b0;
    tick();
    cmp_en = 1'b1;
    tick();
    check("rst_trigger", {31'h0, trig}, 32'h0);
    check("rst_resp", {31'h0, resp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    tick();

    // Sources 2 (prio 1) and 5 (prio 3) rise together.
    bus_wr(5'h04, 32'h24);
    bus_wr(5'h08, 32'h0030_0100);
    src = 8'h24;
    tick(); check("lat_k0", {31'h0, trig}, 32'h0);
    tick(); check("lat_k1", {31'h0, trig}, 32'h0);
    tick(); check("lat_k2", {31'h0, trig}, 32'h1);
    bus_rd(5'h10, d); check("claim_src5", d, 32'd6);
    check("service_trig", {31'h0, trig}, 32'h0);
    bus_wr(5'h10, 32'd5);
    wait_trig("wait_src2");
    bus_rd(5'h10, d); check("claim_src2", d, 32'd3);
    bus_wr(5'h10, 32'd2);
    src = 8'h00;
    tick();

    // Priority equal to threshold never signals.
    bus_wr(5'h04, 32'h08);
    bus_wr(5'h08, 32'h0000_2000);
    bus_wr(5'h0C, 32'd2);
    src = 8'h08;
    repeat (5) tick();
    check("thr_block", {31'h0, trig}, 32'h0);
    bus_wr(5'h0C, 32'd1);
    tick(); tick();
    check("thr_lowered", {31'h0, trig}, 32'h1);
    bus_rd(5'h10, d); check("claim_src3", d, 32'd4);
    bus_wr(5'h10, 32'd3);
    src = 8'h00;
    tick();

    // Equal priority: lowest ID first.
    bus_wr(5'h0C, 32'd0);
    bus_wr(5'h04, 32'h11);
    bus_wr(5'h08, 32'h0005_0005);
    src = 8'h11;
    wait_trig("wait_tie");
    bus_rd(5'h10, d); check("claim_tie0", d, 32'd1);
    bus_wr(5'h10, 32'd0);
    wait_trig("wait_tie4");
    bus_rd(5'h10, d); check("claim_tie4", d, 32'd5);
    bus_wr(5'h10, 32'd4);
    src = 8'h00;
    tick();

    // W1C of the winner while signalling.
    bus_wr(5'h04, 32'h02);
    bus_wr(5'h08, 32'h0000_0010);
    src = 8'h02;
    wait_trig("wait_src1");
    bus_wr(5'h00, 32'h02);
    check("w1c_trig", {31'h0, trig}, 32'h0);
    bus_rd(5'h10, d); check("claim_idle", d, 32'd0);

    // Illegal accesses.
    addr = 5'h04; w_rb = 1'b0; acc = 2'd0; req = 1'b1;
    #1 check("fault_acc", {31'h0, fault}, 32'h1);
    tick(); req = 1'b0; acc = 2'd2;
    check("fault_acc_resp", {31'h0, resp}, 32'h0);
    check("fault_acc_rdata", rdata, 32'h0);
    addr = 5'h14; req = 1'b1;
    #1 check("fault_addr", {31'h0, fault}, 32'h1);
    tick(); req = 1'b0;
    check("fault_addr_resp", {31'h0, resp}, 32'h0);
    addr = 5'h06; w_rb = 1'b1; wdata = 32'hFF; req = 1'b1;
    tick(); req = 1'b0; w_rb = 1'b0;
    bus_rd(5'h04, d); check("fault_no_write", d, 32'h02);

    // Service: mismatched complete, handled pulses, reset mid-signal.
    bus_wr(5'h04, 32'h60);
    bus_wr(5'h08, 32'h0370_0000);
    src = 8'h40;
    wait_trig("wait_src6");
    bus_rd(5'h10, d); check("claim_src6", d, 32'd7);
    bus_wr(5'h10, 32'd3);
    src = 8'h60;
    repeat (5) tick();
    check("bad_complete", {31'h0, trig}, 32'h0);
    bus_rd(5'h10, d); check("claim_in_service", d, 32'd0);
    pulse_handled();
    wait_trig("wait_src5");
    pulse_handled();
    check("handled_signal", {31'h0, trig}, 32'h0);
    bus_rd(5'h00, d); check("pend_after_handled", d, 32'h0);
    src = 8'h40;
    tick();
    src = 8'h60;
    wait_trig("wait_src5_again");
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("mid_rst_trig", {31'h0, trig}, 32'h0);
    check("mid_rst_rdata", rdata, 32'h0);
    bus_rd(5'h04, d); check("rst_en", d, 32'h0);
    bus_rd(5'h08, d); check("rst_prio", d, 32'h0);
    bus_rd(5'h0C, d); check("rst_thr", d, 32'h0);
    bus_rd(5'h00, d); check("rst_pend_edge", d, 32'h60);
    repeat (5) tick();
    check("rst_no_trig", {31'h0, trig}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
